// File: rtl/if_id_skid_pipe.sv
// IF/ID stage register with valid/ready handshake and a 2-entry skid buffer.
// Optional macro IF_ID_STALL_CNT_EN adds a saturating stall_cycles counter port.
module if_id_skid_pipe #(
  parameter int unsigned           XLEN      = 32,
  parameter int unsigned           ILEN      = 32,
  parameter int unsigned           SB_W      = 1,
  parameter logic [ILEN-1:0]       NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [SB_W-1:0] in_sb,
  input  logic            kill_in,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [SB_W-1:0] out_sb
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cycles
`endif
);

  logic            main_valid_r, main_valid_s;
  logic [ILEN-1:0] main_instr_r, main_instr_s;
  logic [XLEN-1:0] main_pc_r,    main_pc_s;
  logic [SB_W-1:0] main_sb_r,    main_sb_s;
  logic            skid_valid_r, skid_valid_s;
  logic [ILEN-1:0] skid_instr_r, skid_instr_s;
  logic [XLEN-1:0] skid_pc_r,    skid_pc_s;
  logic [SB_W-1:0] skid_sb_r,    skid_sb_s;
  logic            in_ready_r;

  logic            accept_s;
  logic            drain_s;
  logic [ILEN-1:0] beat_instr_s;
  logic [SB_W-1:0] beat_sb_s;

  assign accept_s  = in_valid && in_ready_r;
  assign drain_s   = main_valid_r && out_ready;

  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  assign out_instr = main_instr_r;
  assign out_pc    = main_pc_r;
  assign out_sb    = main_sb_r;

  // Incoming beat after kill_in substitution (killed beats become a NOP bubble).
  always_comb begin
    beat_instr_s = in_instr;
    beat_sb_s    = in_sb;
    if (kill_in) begin
      beat_instr_s = NOP_INSTR;
      beat_sb_s    = {SB_W{1'b0}};
    end else begin
      beat_instr_s = in_instr;
      beat_sb_s    = in_sb;
    end
  end

  // Next-state for the main and skid entries.
  always_comb begin
    main_valid_s = main_valid_r;
    main_instr_s = main_instr_r;
    main_pc_s    = main_pc_r;
    main_sb_s    = main_sb_r;
    skid_valid_s = skid_valid_r;
    skid_instr_s = skid_instr_r;
    skid_pc_s    = skid_pc_r;
    skid_sb_s    = skid_sb_r;
    if (flush) begin
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
    end else if (!main_valid_r || drain_s) begin
      if (skid_valid_r) begin
        main_valid_s = 1'b1;
        main_instr_s = skid_instr_r;
        main_pc_s    = skid_pc_r;
        main_sb_s    = skid_sb_r;
        // Refill skid in the same cycle it hands its beat to main.
        if (accept_s) begin
          skid_valid_s = 1'b1;
          skid_instr_s = beat_instr_s;
          skid_pc_s    = in_pc;
          skid_sb_s    = beat_sb_s;
        end else begin
          skid_valid_s = 1'b0;
        end
      end else if (accept_s) begin
        main_valid_s = 1'b1;
        main_instr_s = beat_instr_s;
        main_pc_s    = in_pc;
        main_sb_s    = beat_sb_s;
      end else begin
        main_valid_s = 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_s = 1'b1;
      skid_instr_s = beat_instr_s;
      skid_pc_s    = in_pc;
      skid_sb_s    = beat_sb_s;
    end else begin
      skid_valid_s = skid_valid_r;
    end
  end

  // Entry registers; in_ready is registered from the next skid state.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      main_instr_r <= {ILEN{1'b0}};
      main_pc_r    <= {XLEN{1'b0}};
      main_sb_r    <= {SB_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_instr_r <= {ILEN{1'b0}};
      skid_pc_r    <= {XLEN{1'b0}};
      skid_sb_r    <= {SB_W{1'b0}};
      in_ready_r   <= 1'b1;
    end else begin
      main_valid_r <= main_valid_s;
      main_instr_r <= main_instr_s;
      main_pc_r    <= main_pc_s;
      main_sb_r    <= main_sb_s;
      skid_valid_r <= skid_valid_s;
      skid_instr_r <= skid_instr_s;
      skid_pc_r    <= skid_pc_s;
      skid_sb_r    <= skid_sb_s;
      in_ready_r   <= !skid_valid_s;
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cycles_r;

  assign stall_cycles = stall_cycles_r;

  // Saturating count of cycles where ID holds off a valid beat; flush does not touch it.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_r <= 32'd0;
    end else if (main_valid_r && !out_ready && (stall_cycles_r != 32'hFFFF_FFFF)) begin
      stall_cycles_r <= stall_cycles_r + 32'd1;
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid_pipe.sv
// Directed self-checking bench for if_id_skid_pipe; stall counter checks run when
// IF_ID_STALL_CNT_EN is defined.
module tb_if_id_skid_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [0:0]  in_sb;
  logic        kill_in;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [0:0]  out_sb;
`ifdef IF_ID_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  if_id_skid_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_sb     (in_sb),
    .kill_in   (kill_in),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_sb    (out_sb)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic sb);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr;
    in_sb    = sb;
  endtask

  initial begin
    reset = 1'b1; kill_in = 1'b0; flush = 1'b0; out_ready = 1'b1;
    offer(1'b1, 32'h44, 32'hDEAD_BEEF, 1'b1);

    // 1: reset with in_valid high
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_sb", {31'd0, out_sb}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("rst_no_capture", {31'd0, out_valid}, 32'd0);

    // 2: streaming, out_ready high
    offer(1'b1, 32'h0, 32'h0050_0093, 1'b1);
    tick();
    check("s0_valid", {31'd0, out_valid}, 32'd1);
    check("s0_pc", out_pc, 32'h0);
    check("s0_instr", out_instr, 32'h0050_0093);
    check("s0_sb", {31'd0, out_sb}, 32'd1);
    check("s0_ready", {31'd0, in_ready}, 32'd1);
    offer(1'b1, 32'h4, 32'h0010_0113, 1'b0);
    tick();
    check("s1_pc", out_pc, 32'h4);
    check("s1_instr", out_instr, 32'h0010_0113);
    check("s1_ready", {31'd0, in_ready}, 32'd1);
    offer(1'b1, 32'h8, 32'h0020_81B3, 1'b0);
    tick();
    check("s2_pc", out_pc, 32'h8);
    check("s2_instr", out_instr, 32'h0020_81B3);
    check("s2_ready", {31'd0, in_ready}, 32'd1);
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("s_empty", {31'd0, out_valid}, 32'd0);

    // 3: backpressure fills skid, then drains in order
    out_ready = 1'b0;
    offer(1'b1, 32'h10, 32'h11, 1'b0);
    tick();
    check("bp_a_pc", out_pc, 32'h10);
    check("bp_a_ready", {31'd0, in_ready}, 32'd1);
    offer(1'b1, 32'h14, 32'h22, 1'b0);
    tick();
    check("bp_b_pc", out_pc, 32'h10);
    check("bp_b_ready", {31'd0, in_ready}, 32'd0);
    offer(1'b1, 32'h18, 32'h33, 1'b0);
    tick();
    check("bp_c_held_pc", out_pc, 32'h10);
    check("bp_c_held_instr", out_instr, 32'h11);
    check("bp_c_held_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    tick();
    check("bp_d1_pc", out_pc, 32'h14);
    check("bp_d1_instr", out_instr, 32'h22);
    check("bp_d1_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_d2_pc", out_pc, 32'h18);
    check("bp_d2_instr", out_instr, 32'h33);
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // 4: kill_in turns the beat into a NOP
    offer(1'b1, 32'h100, 32'h00A0_0113, 1'b1);
    kill_in = 1'b1;
    tick();
    check("kill_valid", {31'd0, out_valid}, 32'd1);
    check("kill_instr", out_instr, 32'h0000_0013);
    check("kill_pc", out_pc, 32'h100);
    check("kill_sb", {31'd0, out_sb}, 32'd0);
    kill_in = 1'b0;
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("kill_empty", {31'd0, out_valid}, 32'd0);

    // 5: flush with both entries full and a beat offered
    out_ready = 1'b0;
    offer(1'b1, 32'h300, 32'h66, 1'b0);
    tick();
    offer(1'b1, 32'h304, 32'h77, 1'b0);
    tick();
    check("fl_full_ready", {31'd0, in_ready}, 32'd0);
    offer(1'b1, 32'h200, 32'h88, 1'b0);
    flush = 1'b1;
    tick();
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_ready", {31'd0, in_ready}, 32'd1);
    check("fl_data_hold", out_pc, 32'h300);
    flush = 1'b0;
    out_ready = 1'b1;
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("fl_nothing", {31'd0, out_valid}, 32'd0);
    // flush while accepting into an empty stage discards the beat
    offer(1'b1, 32'h208, 32'h99, 1'b0);
    flush = 1'b1;
    tick();
    check("fl_acc_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    offer(1'b1, 32'h400, 32'h55, 1'b0);
    tick();
    check("fl_next_valid", {31'd0, out_valid}, 32'd1);
    check("fl_next_pc", out_pc, 32'h400);
    check("fl_next_instr", out_instr, 32'h55);
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("fl_next_drain", {31'd0, out_valid}, 32'd0);

`ifdef IF_ID_STALL_CNT_EN
    // 6: stall counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("sc_rst0", stall_cycles, 32'd0);
    out_ready = 1'b0;
    offer(1'b1, 32'h500, 32'hAA, 1'b0);
    tick();
    offer(1'b0, 32'h0, 32'h0, 1'b0);
    check("sc_start", stall_cycles, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    check("sc_five", stall_cycles, 32'd5);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sc_after_flush", stall_cycles, 32'd5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("sc_after_reset", stall_cycles, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_skid_pipe.md
Name: if_id_skid_pipe

Overview:
Parametrised IF/ID stage register for the RISC-V core, replacing the single-entry stall/NOP pipe register. It adds a valid/ready handshake on both sides and a 2-entry skid buffer, so in_ready is registered and the stage still sustains one instruction per cycle under backpressure. It also provides flush (squash all held entries) and kill_in (convert the incoming beat to a NOP bubble), and carries configurable-width PC and sideband fields.

Parameters:
XLEN, 32, width of the PC field.
ILEN, 32, width of the instruction field.
SB_W, 1, sideband width carried with each beat (e.g. predicted-taken); must be ≥1.
NOP_INSTR, 32'h00000013, instruction value inserted on kill_in (addi x0,x0,0).

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  IF presents a beat.
in_ready  out  1  stage can accept; registered, equals !skid_valid.
in_instr  in  ILEN  fetched instruction.
in_pc  in  XLEN  PC of in_instr.
in_sb  in  SB_W  sideband.
kill_in  in  1  qualifies the accepted beat: store it as a NOP.
flush  in  1  squash all held and incoming beats.
out_valid  out  1  ID-facing beat valid.
out_ready  in  1  ID consumes the beat.
out_instr  out  ILEN  instruction to ID.
out_pc  out  XLEN  PC to ID.
out_sb  out  SB_W  sideband to ID.

Behaviour:
- Storage: main entry (drives the outputs directly) and skid entry. Each entry has a valid bit plus instr/pc/sb fields.
- accept = in_valid && in_ready; drain = out_valid && out_ready.
- Reset, evaluated at the clock edge while reset=1: both valids cleared; all data registers cleared to 0. After reset, out_valid=0, out_instr=0, out_pc=0, out_sb=0, in_ready=1. Inputs in a reset cycle are ignored.
- Reset while an entry is held: the entry is discarded without being emitted.
- Priority, highest first: reset > flush > normal operation.
- flush: next cycle main_valid=0 and skid_valid=0, so in_ready=1. A beat offered in the flush cycle is discarded even if accepted. Data fields hold their previous values. A drain in the flush cycle still counts as a completed transfer.
- Normal update, main entry:
  - If main is empty or drain: main loads skid if skid_valid, otherwise loads the accepted beat; if neither, main_valid goes to 0.
  - Otherwise main holds. Outputs are stable while out_valid && !out_ready.
- Normal update, skid entry:
  - Loads the accepted beat only when main stays occupied and no drain occurs, or when main is refilled from skid in the same cycle as an accept.
  - Otherwise skid_valid clears when its content moves to main.
- Ordering: strict FIFO; no beat is dropped or duplicated except by flush or reset.
- kill_in (only meaningful on accept): stored instr = NOP_INSTR, sb = 0, pc = in_pc. kill_in without accept has no effect.
- Latency: an accepted beat appears on the outputs the next cycle when the stage is empty. Throughput is 1 beat/cycle with out_ready held high.
- in_ready deasserts the cycle after the skid entry fills and reasserts the cycle after it empties. There is no combinational path from out_ready to in_ready.
- Simultaneous accept + drain while both entries are full cannot occur, because in_ready=0 in that state.

Optional Feature:
Macro IF_ID_STALL_CNT_EN.
- Defined: adds output port stall_cycles (32 bits). It increments by 1 each cycle where out_valid && !out_ready, and saturates at 32'hFFFFFFFF. It clears to 0 on reset and is not affected by flush.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset for 2 cycles with in_valid=1 -> out_valid=0, out_instr=0, out_pc=0, in_ready=1; no beat is captured.
2. Stream with out_ready=1: pc 0x0/0x4/0x8, instr 0x00500093/0x00100113/0x002081B3, on consecutive cycles -> each appears 1 cycle later with no bubbles; in_ready stays 1.
3. Backpressure: out_ready=0, accept A(pc 0x10) then B(pc 0x14) -> out_pc holds 0x10 and in_ready=0 the cycle after B. C(pc 0x18) is offered and held off. Raise out_ready -> outputs 0x10, 0x14, 0x18 in order on consecutive cycles.
4. kill_in with instr 0x00A00113, pc 0x100 -> out_instr=0x00000013, out_pc=0x100, out_sb=0.
5. Flush with both entries full and in_valid=1 (pc 0x200) -> next cycle out_valid=0, in_ready=1; pc 0x200 and the held beats are never emitted. The next accepted beat is emitted normally.
6. With IF_ID_STALL_CNT_EN defined: hold out_ready=0 for 5 cycles with out_valid=1 -> stall_cycles=5; flush -> stall_cycles remains 5; reset -> 0.
